// File: rtl/signext_pkg.sv
// Shared types for the immediate sign/zero-extension pipe.
// Mode and skid-buffer state encodings.
package signext_pkg;

  typedef enum logic [1:0] {
    ZEXT     = 2'b00,
    SEXT     = 2'b01,
    SEXT_SHL = 2'b10,
    RSVD     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b10
  } skid_e;

endpackage

// File: rtl/signext_pipe_if.sv
// Valid/ready bundle for signext_pipe: input side and output side.
// master = producer/consumer environment, slave = the pipe.
interface signext_pipe_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err
  );

endinterface

// File: rtl/signext_core.sv
// Combinational immediate extension: ZEXT, SEXT, SEXT_SHL, and
// reserved mode (SEXT result flagged with err).
module signext_core
  import signext_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int SHAMT = 1
) (
  input  logic [IN_W-1:0]  data_i,
  input  mode_e            mode_i,
  output logic [OUT_W-1:0] data_o,
  output logic             err_o
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{(OUT_W-IN_W){1'b0}}, data_i};
  assign sext = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};

  always_comb begin
    data_o = sext;
    err_o  = 1'b0;
    unique case (mode_i)
      ZEXT:     data_o = zext;
      SEXT:     data_o = sext;
      SEXT_SHL: data_o = sext << SHAMT;
      RSVD:     err_o  = 1'b1;
      default:  data_o = sext;
    endcase
  end

endmodule

// File: rtl/signext_pipe.sv
// Immediate extension pipe with a 2-entry skid buffer on the output.
// Optional SIGNEXT_PIPE_STATS_EN adds a saturating negative-result counter.
module signext_pipe
  import signext_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8,
  parameter int SHAMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  signext_pipe_if.slave    bus
`ifdef SIGNEXT_PIPE_STATS_EN
  ,
  output logic [15:0]      neg_count
`endif
);

  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] data;
  } entry_t;

  skid_e  state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t res;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire, out_valid;
  logic [OUT_W-1:0] res_data;
  logic   res_err;

  signext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHAMT(SHAMT)
  ) u_core (
    .data_i(bus.in_data),
    .mode_i(mode_e'(bus.in_mode)),
    .data_o(res_data),
    .err_o (res_err)
  );

  assign res      = '{err: res_err, data: res_data};
  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (in_fire) state_d = S_ONE;
      S_ONE: begin
        if (in_fire && !out_fire)      state_d = S_FULL;
        else if (!in_fire && out_fire) state_d = S_EMPTY;
      end
      S_FULL:  if (out_fire) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // head is always the oldest entry; tail only fills while head is stalled
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      S_EMPTY: if (in_fire) head_d = res;
      S_ONE: begin
        if (in_fire && out_fire) head_d = res;
        else if (in_fire)        tail_d = res;
      end
      S_FULL:  if (out_fire) head_d = tail_q;
      default: head_d = head_q;
    endcase
  end

  always_comb begin
    in_ready_d    = (state_d != S_FULL);
    out_valid     = (state_q != S_EMPTY);
    bus.out_valid = out_valid;
    bus.out_data  = head_q.data;
    bus.out_err   = head_q.err;
    bus.in_ready  = in_ready_q;
  end

`ifdef SIGNEXT_PIPE_STATS_EN
  logic [15:0] neg_count_q, neg_count_d;

  always_comb begin
    neg_count_d = neg_count_q;
    if (out_fire && head_q.data[OUT_W-1] && neg_count_q != 16'hFFFF)
      neg_count_d = neg_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_count_q <= '0;
    else        neg_count_q <= neg_count_d;
  end

  assign neg_count = neg_count_q;
`endif

endmodule

// File: tb/tb_signext_pipe.sv
// Directed self-checking bench for signext_pipe (IN_W=4, OUT_W=8, SHAMT=1).
// Define SIGNEXT_PIPE_STATS_EN to also exercise neg_count.
module tb_signext_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  signext_pipe_if #(.IN_W(4), .OUT_W(8)) bus ();

`ifdef SIGNEXT_PIPE_STATS_EN
  logic [15:0] neg_count;
`endif

  signext_pipe #(
    .IN_W (4),
    .OUT_W(8),
    .SHAMT(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef SIGNEXT_PIPE_STATS_EN
    ,
    .neg_count(neg_count)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_data !== 8'h00) begin
      n_err++;
      $display("FAIL rst_out_data got %h want 00", bus.out_data);
    end
    n_cmp++;
    if (bus.out_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_err got %b want 0", bus.out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ready_rise got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_sext_seq;
    logic [3:0] din [8] = '{4'h0, 4'h1, 4'hE, 4'h3, 4'h8, 4'h7, 4'hA, 4'hF};
    logic [7:0] dexp[8] = '{8'h00, 8'h01, 8'hFE, 8'h03,
                            8'hF8, 8'h07, 8'hFA, 8'hFF};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = 2'b01;
      bus.in_data  = din[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== dexp[i]) begin
        n_err++;
        $display("FAIL sext[%0d] got v=%b d=%h want v=1 d=%h",
                 i, bus.out_valid, bus.out_data, dexp[i]);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sext_drain got v=%b want 0", bus.out_valid);
    end
  endtask

`ifdef SIGNEXT_PIPE_STATS_EN
  task automatic test_stats;
    n_cmp++;
    if (neg_count !== 16'd4) begin
      n_err++;
      $display("FAIL neg_count got %0d want 4", neg_count);
    end
    force dut.neg_count_q = 16'hFFFF;
    #1;
    release dut.neg_count_q;
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'b01;
    bus.in_data  = 4'h8;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (neg_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL neg_sat got %h want FFFF", neg_count);
    end
  endtask
`endif

  task automatic test_modes;
    logic [1:0] m   [6] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [3:0] din [6] = '{4'hE, 4'h8, 4'hE, 4'h8, 4'h9, 4'h1};
    logic [7:0] dexp[6] = '{8'h0E, 8'h08, 8'hFC, 8'hF0, 8'hF9, 8'h01};
    logic       eexp[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = m[i];
      bus.in_data  = din[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== dexp[i] ||
          bus.out_err !== eexp[i]) begin
        n_err++;
        $display("FAIL mode[%0d] got v=%b d=%h e=%b want v=1 d=%h e=%b",
                 i, bus.out_valid, bus.out_data, bus.out_err,
                 dexp[i], eexp[i]);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b01;
    bus.in_data   = 4'h3;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== 8'h03) begin
      n_err++;
      $display("FAIL b2b_first got r=%b d=%h want r=1 d=03",
               bus.in_ready, bus.out_data);
    end
    bus.in_data = 4'hE;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h03) begin
      n_err++;
      $display("FAIL b2b_full got r=%b d=%h want r=0 d=03",
               bus.in_ready, bus.out_data);
    end
    bus.in_data = 4'h5;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h03 ||
        bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_hold got r=%b v=%b d=%h want r=0 v=1 d=03",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_data !== 8'hFE || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_drain1 got d=%h r=%b want d=FE r=1",
               bus.out_data, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 8'h05 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_drain2 got v=%b d=%h want v=1 d=05",
               bus.out_valid, bus.out_data);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_empty got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_full;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b01;
    bus.in_data   = 4'h7;
    @(posedge clk);
    #1;
    bus.in_data = 4'h8;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rf_full got r=%b want 0", bus.in_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rf_async got v=%b d=%h r=%b want v=0 d=00 r=0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rf_stale[%0d] got v=%b d=%h want v=0",
                 i, bus.out_valid, bus.out_data);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02) begin
      n_err++;
      $display("FAIL rf_after got v=%b d=%h want v=1 d=02",
               bus.out_valid, bus.out_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_sext_seq();
`ifdef SIGNEXT_PIPE_STATS_EN
    test_stats();
`endif
    test_modes();
    test_back_to_back();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
